// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the trap sequencer: privilege levels, exception codes,
// CSR addresses, mstatus bit positions and FSM state encodings.
package trap_sequencer_pkg;

  localparam logic [1:0] XLEN_32b = 2'd1;
  localparam logic [1:0] XLEN_64b = 2'd2;

  localparam logic [1:0] USER    = 2'b00;
  localparam logic [1:0] MACHINE = 2'b11;

  // 0xF is a store page fault in mcause, which this core never raises.
  localparam logic [3:0] NO_E                  = 4'hF;
  localparam logic [3:0] E_INSTR_MISALIGNED    = 4'd0;
  localparam logic [3:0] E_INSTR_ACCESS_FAULT  = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INSTR       = 4'd2;
  localparam logic [3:0] E_BREAKPOINT          = 4'd3;
  localparam logic [3:0] E_LOAD_MISALIGNED     = 4'd4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT   = 4'd5;
  localparam logic [3:0] E_STORE_MISALIGNED    = 4'd6;
  localparam logic [3:0] E_STORE_ACCESS_FAULT  = 4'd7;
  localparam logic [3:0] E_ECALL               = 4'd8;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_T_EPC    = 3'd1,
    ST_T_CAUSE  = 3'd2,
    ST_T_TVAL   = 3'd3,
    ST_T_STATUS = 3'd4,
    ST_T_JUMP   = 3'd5,
    ST_R_STATUS = 3'd6,
    ST_R_JUMP   = 3'd7
  } trap_state_e;

  // Reserved MPP encodings fall back to USER.
  function automatic logic [1:0] legal_priv(input logic [1:0] p);
    return (p == MACHINE) ? MACHINE : USER;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR-facing signal bundle of the trap sequencer.
// master = pipeline side driving the inputs, slave = the sequencer.
interface trap_sequencer_if #(parameter int W = 64);
  logic [3:0]   i_exception_code_f;
  logic [3:0]   i_exception_code_e;
  logic [W-1:0] i_pc_f;
  logic [W-1:0] i_pc_e;
  logic [W-1:0] i_alu_out_e;
  logic         i_mret_e;
  logic [W-1:0] i_mstatus;
  logic [W-1:0] i_mtvec;
  logic [W-1:0] i_mepc;
  logic [1:0]   o_current_privilege;
  logic         o_stall;
  logic         o_flush;
  logic         o_csr_we;
  logic [11:0]  o_csr_addr;
  logic [W-1:0] o_csr_wdata;
  logic         o_redirect_en;
  logic [W-1:0] o_redirect_pc;
  logic         o_busy;

  modport master (
    output i_exception_code_f, i_exception_code_e, i_pc_f, i_pc_e, i_alu_out_e,
           i_mret_e, i_mstatus, i_mtvec, i_mepc,
    input  o_current_privilege, o_stall, o_flush, o_csr_we, o_csr_addr,
           o_csr_wdata, o_redirect_en, o_redirect_pc, o_busy
  );

  modport slave (
    input  i_exception_code_f, i_exception_code_e, i_pc_f, i_pc_e, i_alu_out_e,
           i_mret_e, i_mstatus, i_mtvec, i_mepc,
    output o_current_privilege, o_stall, o_flush, o_csr_we, o_csr_addr,
           o_csr_wdata, o_redirect_en, o_redirect_pc, o_busy
  );
endinterface

// File: rtl/trap_sequencer_mstatus_update.sv
// Combinational mstatus rewrite shared by trap entry (MPP/MPIE/MIE stacking)
// and mret (MIE/MPIE unstacking, MPP cleared to USER).
module mstatus_update
  import trap_sequencer_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] mstatus_i,
  input  logic [1:0]   priv_i,
  input  logic         is_return_i,
  output logic [W-1:0] mstatus_o
);

  always_comb begin
    mstatus_o = mstatus_i;
    if (is_return_i) begin
      mstatus_o[MSTATUS_MIE]                   = mstatus_i[MSTATUS_MPIE];
      mstatus_o[MSTATUS_MPIE]                  = 1'b1;
      mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = USER;
    end else begin
      mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_i;
      mstatus_o[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
      mstatus_o[MSTATUS_MIE]                   = 1'b0;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap-entry / mret sequencer; owns the current-privilege register.
// Build option TRAP_MTVAL_EN adds the T_TVAL state and the mtval write.
//   state     | meaning
//   IDLE      | watching E/F exception codes and mret
//   T_EPC     | write mepc
//   T_CAUSE   | write mcause
//   T_TVAL    | write mtval (TRAP_MTVAL_EN only)
//   T_STATUS  | write stacked mstatus, privilege -> MACHINE
//   T_JUMP    | redirect fetch to mtvec
//   R_STATUS  | write unstacked mstatus, privilege -> old MPP
//   R_JUMP    | redirect fetch to mepc
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [1:0] XLEN = XLEN_64b
) (
  input logic             i_clk,
  input logic             i_rst,
  trap_sequencer_if.slave bus
);

  localparam int W = 1 << (int'(XLEN) + 4);

  trap_state_e  state_q, state_d;
  logic [1:0]   priv_q, priv_d;
  logic [3:0]   cause_q, cause_d;
  logic [W-1:0] epc_q, epc_d;
`ifdef TRAP_MTVAL_EN
  logic [W-1:0] tval_q, tval_d;
`endif

  logic         ms_return;
  logic [W-1:0] ms_new;
  logic         csr_we;
  logic [11:0]  csr_addr;
  logic [W-1:0] csr_wdata;
  logic         redirect_en;
  logic [W-1:0] redirect_pc;

  mstatus_update #(.W(W)) u_mstatus_update (
    .mstatus_i   (bus.i_mstatus),
    .priv_i      (priv_q),
    .is_return_i (ms_return),
    .mstatus_o   (ms_new)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      priv_q  <= MACHINE;
      cause_q <= '0;
      epc_q   <= '0;
`ifdef TRAP_MTVAL_EN
      tval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      priv_q  <= priv_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
`ifdef TRAP_MTVAL_EN
      tval_q  <= tval_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    priv_d      = priv_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
`ifdef TRAP_MTVAL_EN
    tval_d      = tval_q;
`endif
    ms_return   = 1'b0;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    redirect_en = 1'b0;
    redirect_pc = '0;

    case (state_q)
      ST_IDLE: begin
        // The older instruction wins: E exception, then mret, then F exception.
        if (bus.i_exception_code_e != NO_E) begin
          cause_d = bus.i_exception_code_e;
          epc_d   = bus.i_pc_e;
`ifdef TRAP_MTVAL_EN
          tval_d  = bus.i_alu_out_e;
`endif
          state_d = ST_T_EPC;
        end else if (bus.i_mret_e) begin
          state_d = ST_R_STATUS;
        end else if (bus.i_exception_code_f != NO_E) begin
          cause_d = bus.i_exception_code_f;
          epc_d   = bus.i_pc_f;
`ifdef TRAP_MTVAL_EN
          tval_d  = bus.i_pc_f;
`endif
          state_d = ST_T_EPC;
        end
      end
      ST_T_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = epc_q;
        state_d   = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = {{(W-4){1'b0}}, cause_q};
`ifdef TRAP_MTVAL_EN
        state_d   = ST_T_TVAL;
`else
        state_d   = ST_T_STATUS;
`endif
      end
`ifdef TRAP_MTVAL_EN
      ST_T_TVAL: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MTVAL;
        csr_wdata = tval_q;
        state_d   = ST_T_STATUS;
      end
`endif
      ST_T_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = ms_new;
        priv_d    = MACHINE;
        state_d   = ST_T_JUMP;
      end
      ST_T_JUMP: begin
        redirect_en = 1'b1;
        redirect_pc = {bus.i_mtvec[W-1:2], 2'b00};
        state_d     = ST_IDLE;
      end
      ST_R_STATUS: begin
        ms_return = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = ms_new;
        priv_d    = legal_priv(bus.i_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
        state_d   = ST_R_JUMP;
      end
      ST_R_JUMP: begin
        redirect_en = 1'b1;
        redirect_pc = bus.i_mepc;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_current_privilege = priv_q;
  assign bus.o_busy              = (state_q != ST_IDLE);
  assign bus.o_stall             = (state_q != ST_IDLE);
  assign bus.o_flush             = (state_q != ST_IDLE);
  assign bus.o_csr_we            = csr_we;
  assign bus.o_csr_addr          = csr_addr;
  assign bus.o_csr_wdata         = csr_wdata;
  assign bus.o_redirect_en       = redirect_en;
  assign bus.o_redirect_pc       = redirect_pc;

endmodule
